// File: rtl/mdc_commutator_ctrl.sv
// Sequencer for the radix-2 MDC FFT pipeline: phase counter, commutator swap selects,
// global enable, input backpressure, end-of-frame drain and output valid/sop tagging.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  S_IDLE  | no frame in flight, cnt=0, first valid pair starts a frame
//  S_RUN   | accepting pairs, stalls on gaps mid-frame
//  S_DRAIN | flushing the pipeline for one full frame period, input blocked
module mdc_commutator_ctrl #(
    parameter int LOG2N = 5,
    parameter int PIPE  = 1,
    localparam int NS   = LOG2N - 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_sop,
    output logic          in_ready,
    output logic          en,
    output logic [NS-1:0] sw_sel,
    output logic          out_valid,
    output logic          out_sop,
    output logic          busy,
    output logic          err_sop
);

    localparam int CW  = LOG2N - 1;
    localparam int N2  = 1 << CW;
    localparam int LAT = (N2 - 1) + LOG2N * PIPE;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [LAT-1:0]  tv_q, tv_d;
    logic [LAT-1:0]  ts_q, ts_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic            acc;
    logic            pend;

    // Cycle at which the first pair of a frame reaches stage k's commutator.
    function automatic int arr_off(input int k);
        int t;
        t = (k + 1) * PIPE;
        for (int j = 0; j < k; j++) begin
            t = t + (1 << (LOG2N - 2 - j));
        end
        return t;
    endfunction

    for (genvar k = 0; k < NS; k++) begin : g_sw
        localparam logic [CW-1:0] TK = CW'(arr_off(k));
        logic [CW-1:0] ph;
        assign ph        = cnt_q - TK;
        assign sw_sel[k] = ph[LOG2N-2-k];
    end

    assign pend = |tv_q;

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b1;
        en       = 1'b0;
        case (state_q)
            S_IDLE: begin
                en = in_valid;
                if (in_valid) state_d = S_RUN;
            end
            S_RUN: begin
                if (cnt_q != '0) begin
                    en = in_valid;
                end else if (in_valid) begin
                    en = 1'b1;
                end else begin
                    en      = 1'b0;
                    state_d = pend ? S_DRAIN : S_IDLE;
                end
            end
            S_DRAIN: begin
                in_ready = 1'b0;
                en       = 1'b1;
                // Drain a whole frame period so cnt stays frame-aligned.
                if (cnt_q == CW'(N2 - 1)) state_d = pend ? S_RUN : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        acc    = in_valid & in_ready;
        cnt_d  = en ? cnt_q + 1'b1 : cnt_q;
        tv_d   = en ? {tv_q[LAT-2:0], acc} : tv_q;
        ts_d   = en ? {ts_q[LAT-2:0], acc & in_sop} : ts_q;
        err_d  = acc & (in_sop ? (cnt_q != '0) : (cnt_q == '0));
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tv_q    <= '0;
            ts_q    <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tv_q    <= tv_d;
            ts_q    <= ts_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = tv_q[LAT-1] & en;
    assign out_sop   = ts_q[LAT-1] & en;
    assign busy      = busy_q;
    assign err_sop   = err_q;

endmodule

// File: tb/tb_mdc_commutator_ctrl.sv
// Scoreboard bench for mdc_commutator_ctrl: driver pushes expected output tags,
// a monitor pops them whenever the controller presents a valid output pair.
module tb_mdc_commutator_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sop = 1'b0;
    logic       in_ready;
    logic       en;
    logic [3:0] sw_sel;
    logic       out_valid;
    logic       out_sop;
    logic       busy;
    logic       err_sop;

    mdc_commutator_ctrl #(.LOG2N(5), .PIPE(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_sop   (in_sop),
        .in_ready (in_ready),
        .en       (en),
        .sw_sel   (sw_sel),
        .out_valid(out_valid),
        .out_sop  (out_sop),
        .busy     (busy),
        .err_sop  (err_sop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic sop;
        int   idx;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;
    int   en_cnt = 0;
    logic last_bad = 1'b0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endfunction

    // Hand-derived swap pattern: bit3(c-1), bit2(c-10), bit1(c-15), bit0(c-2).
    function automatic int exp_sw(input int c);
        logic [3:0] a, b, d, e;
        a = 4'(c - 1);
        b = 4'(c - 10);
        d = 4'(c - 15);
        e = 4'(c - 2);
        return int'({e[0], d[1], b[2], a[3]});
    endfunction

    // Monitor: latency is measured in en-cycles, 20 after acceptance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("out_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_sop", out_sop, e.sop);
                    chk("out_latency", en_cnt, e.idx);
                end
            end
            if (en) en_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input logic v, input logic s, input logic acc, input logic bad);
        @(posedge clk);
        #1;
        in_valid = v;
        in_sop   = s;
        if (acc) q.push_back('{s, en_cnt + 20});
        @(negedge clk);
        chk("err_sop", err_sop, last_bad);
        last_bad = bad;
    endtask

    task automatic send_frame(input logic sop0, input int sop_extra,
                              input int stall_at, input int stall_len);
        logic s;
        logic bad;
        for (int i = 0; i < 16; i++) begin
            if (i == stall_at) begin
                for (int g = 0; g < stall_len; g++) begin
                    cyc(1'b0, 1'b0, 1'b0, 1'b0);
                    chk("stall_en", en, 0);
                    chk("stall_sw", sw_sel, exp_sw(i));
                    chk("stall_in_ready", in_ready, 1);
                end
            end
            s   = (i == 0) ? sop0 : (i == sop_extra);
            bad = (i == 0) ? !sop0 : s;
            cyc(1'b1, s, 1'b1, bad);
            chk("run_en", en, 1);
            chk("run_in_ready", in_ready, 1);
            chk("run_sw", sw_sel, exp_sw(i));
        end
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 200; n++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            if (!busy) break;
        end
        chk("idle_reached", busy, 0);
        chk("idle_in_ready", in_ready, 1);
        chk("sb_empty", q.size(), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sop", out_sop, 0);
        chk("rst_err_sop", err_sop, 0);
        chk("rst_en", en, 0);
        chk("rst_sw", sw_sel, exp_sw(0));
        rst_n = 1'b1;

        // Single frame followed by two drain blocks.
        send_frame(1'b1, -1, -1, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("drain1_entry_en", en, 0);
        chk("drain1_entry_busy", busy, 1);
        for (int j = 0; j < 16; j++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            chk("drain1_in_ready", in_ready, 0);
            chk("drain1_en", en, 1);
            chk("drain1_sw", sw_sel, exp_sw(j));
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("drain2_entry_en", en, 0);
        chk("drain2_entry_in_ready", in_ready, 1);
        for (int j = 0; j < 16; j++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            chk("drain2_in_ready", in_ready, 0);
            chk("drain2_en", en, 1);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_in_ready", in_ready, 1);
        chk("t1_sb_empty", q.size(), 0);

        // Back-to-back frames: no drain between them.
        send_frame(1'b1, -1, -1, 0);
        send_frame(1'b1, -1, -1, 0);
        send_frame(1'b1, -1, -1, 0);
        wait_idle();

        // Five-cycle input gap at cnt=7.
        send_frame(1'b1, -1, 7, 5);
        wait_idle();

        // Misplaced sop at cnt=3, then a frame missing its sop.
        send_frame(1'b1, 3, -1, 0);
        send_frame(1'b0, -1, -1, 0);
        wait_idle();

        // Reset pulse in the middle of a drain.
        send_frame(1'b1, -1, -1, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 10; j++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_pre_in_ready", in_ready, 0);
        chk("t5_pre_sw", sw_sel, exp_sw(9));
        #2;
        rst_n = 1'b0;
        q.delete();
        last_bad = 1'b0;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_out_valid", out_valid, 0);
        chk("t5_rst_out_sop", out_sop, 0);
        chk("t5_rst_err", err_sop, 0);
        chk("t5_rst_en", en, 0);
        chk("t5_rst_in_ready", in_ready, 1);
        chk("t5_rst_sw", sw_sel, exp_sw(0));
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        send_frame(1'b1, -1, -1, 0);
        wait_idle();

        // Input offered during drain is blocked; pair at the wrap starts a frame.
        send_frame(1'b1, -1, -1, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 16; j++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            chk("t6_drain_in_ready", in_ready, 0);
            chk("t6_drain_en", en, 1);
        end
        send_frame(1'b1, -1, -1, 0);
        wait_idle();

        chk("final_sb_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
